// File: rtl/flash_sample_unpacker.sv
// flash_sample_unpacker
//   Requests packed words from the flash read controller and splits each word
//   into SAMPLES_PER_WORD samples, lowest slice first or highest slice first.
//   The samples go into a small FIFO, and one sample leaves it per sample_tick.
//   Everything runs on one clock. sample_tick marks the audio sample rate.
//
// Ports
//   clock, reset       system clock, asynchronous active-high reset
//   enable             allows new word requests
//   flush              synchronous clear of buffered samples and of any unpack
//   reverse            unpack order for the next accepted word (1 = high first)
//   sample_tick        audio-rate strobe that pops one sample
//   read_data          word from the flash reader
//   data_valid         read_data valid this cycle
//   word_request       one-cycle request for the next flash word
//   audio_out          current output sample
//   sample_strobe      pulses the cycle after audio_out is loaded
//   underrun           pulses the cycle after a tick found no sample
//   fill_level         FIFO occupancy
//   underrun_count     saturating underrun counter
//
// state   | meaning
// IDLE    | waiting for enable and room for a whole word
// REQUEST | word_request is high this cycle
// WAIT    | waiting for data_valid
// UNPACK  | pushing one slice per cycle
// DISCARD | flushed while a word was outstanding; drop the next data_valid

module flash_sample_unpacker #(
    parameter int WORD_WIDTH   = 32,
    parameter int SAMPLE_WIDTH = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          flush,
    input  logic                          reverse,
    input  logic                          sample_tick,
    input  logic [WORD_WIDTH-1:0]         read_data,
    input  logic                          data_valid,
    output logic                          word_request,
    output logic [SAMPLE_WIDTH-1:0]       audio_out,
    output logic                          sample_strobe,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic [15:0]                   underrun_count
);

    localparam int SPW    = WORD_WIDTH / SAMPLE_WIDTH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam int IDX_W  = (SPW > 1) ? $clog2(SPW) : 1;

    localparam logic [FILL_W-1:0] DEPTH_C  = FILL_W'(FIFO_DEPTH);
    localparam logic [FILL_W-1:0] SPW_C    = FILL_W'(SPW);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(SPW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQUEST,
        S_WAIT,
        S_UNPACK,
        S_DISCARD
    } state_t;

    state_t                  state_q, state_d;
    logic [WORD_WIDTH-1:0]   word_q, word_d;
    logic                    rev_q, rev_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [SAMPLE_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [SAMPLE_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]       fill_q, fill_d;
    logic                    word_request_q, word_request_d;
    logic [SAMPLE_WIDTH-1:0] audio_out_q, audio_out_d;
    logic                    sample_strobe_q, sample_strobe_d;
    logic                    underrun_q, underrun_d;
    logic [15:0]             underrun_count_q, underrun_count_d;

    logic                    push;
    logic                    pop;
    logic                    space_ok;
    logic [IDX_W-1:0]        sel;
    logic [SAMPLE_WIDTH-1:0] push_data;

    assign word_request   = word_request_q;
    assign audio_out      = audio_out_q;
    assign sample_strobe  = sample_strobe_q;
    assign underrun       = underrun_q;
    assign fill_level     = fill_q;
    assign underrun_count = underrun_count_q;

    // Only one word is ever in flight, so checking for a whole word of room
    // before requesting guarantees the unpack pushes cannot overflow.
    assign space_ok = (DEPTH_C - fill_q) >= SPW_C;

    // Pop uses the registered fill, so a sample pushed this edge can only
    // leave on a later edge. A tick during flush counts as an underrun.
    assign pop = sample_tick && !flush && (fill_q != '0);

    always_comb begin
        sel       = rev_q ? (IDX_LAST - idx_q) : idx_q;
        push_data = '0;
        for (int i = 0; i < SPW; i++) begin
            if (sel == IDX_W'(i)) begin
                push_data = word_q[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        rev_d          = rev_q;
        idx_d          = idx_q;
        word_request_d = 1'b0;
        push           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && !flush && space_ok) begin
                    state_d        = S_REQUEST;
                    word_request_d = 1'b1;
                end
            end
            S_REQUEST: begin
                state_d = flush ? S_DISCARD : S_WAIT;
            end
            S_WAIT: begin
                if (flush) begin
                    // A word arriving together with the flush is the one to drop.
                    state_d = data_valid ? S_IDLE : S_DISCARD;
                end else if (data_valid) begin
                    word_d  = read_data;
                    rev_d   = reverse;
                    idx_d   = '0;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    push  = 1'b1;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DISCARD: begin
                if (data_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_d            = mem_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        fill_d           = fill_q;
        audio_out_d      = audio_out_q;
        sample_strobe_d  = 1'b0;
        underrun_d       = 1'b0;
        underrun_count_d = underrun_count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                audio_out_d     = mem_q[rd_ptr_q];
                rd_ptr_d        = rd_ptr_q + PTR_W'(1);
                sample_strobe_d = 1'b1;
            end
            fill_d = fill_q + FILL_W'(push) - FILL_W'(pop);
        end

        if (sample_tick && !pop) begin
            underrun_d = 1'b1;
            if (underrun_count_q != 16'hFFFF) begin
                underrun_count_d = underrun_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            word_q           <= '0;
            rev_q            <= 1'b0;
            idx_q            <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            fill_q           <= '0;
            word_request_q   <= 1'b0;
            audio_out_q      <= '0;
            sample_strobe_q  <= 1'b0;
            underrun_q       <= 1'b0;
            underrun_count_q <= '0;
        end else begin
            state_q          <= state_d;
            word_q           <= word_d;
            rev_q            <= rev_d;
            idx_q            <= idx_d;
            mem_q            <= mem_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            fill_q           <= fill_d;
            word_request_q   <= word_request_d;
            audio_out_q      <= audio_out_d;
            sample_strobe_q  <= sample_strobe_d;
            underrun_q       <= underrun_d;
            underrun_count_q <= underrun_count_d;
        end
    end

endmodule

// File: tb/tb_flash_sample_unpacker.sv
// Testbench for flash_sample_unpacker: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// queue-based behavioural model.

module tb_flash_sample_unpacker;

    localparam int WW    = 32;
    localparam int SW    = 16;
    localparam int DEPTH = 4;
    localparam int SPW   = WW / SW;
    localparam int FW    = $clog2(DEPTH) + 1;

    logic          clock;
    logic          reset;
    logic          enable;
    logic          flush;
    logic          reverse;
    logic          sample_tick;
    logic [WW-1:0] read_data;
    logic          data_valid;
    logic          word_request;
    logic [SW-1:0] audio_out;
    logic          sample_strobe;
    logic          underrun;
    logic [FW-1:0] fill_level;
    logic [15:0]   underrun_count;

    flash_sample_unpacker #(
        .WORD_WIDTH   (WW),
        .SAMPLE_WIDTH (SW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .flush          (flush),
        .reverse        (reverse),
        .sample_tick    (sample_tick),
        .read_data      (read_data),
        .data_valid     (data_valid),
        .word_request   (word_request),
        .audio_out      (audio_out),
        .sample_strobe  (sample_strobe),
        .underrun       (underrun),
        .fill_level     (fill_level),
        .underrun_count (underrun_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_req: request visible this cycle; m_wait: awaiting the word;
    // m_drop: next word is to be thrown away; m_slices: samples still to push.
    logic          m_req, m_wait, m_drop;
    logic [SW-1:0] m_fifo[$];
    logic [SW-1:0] m_slices[$];
    logic [SW-1:0] e_audio;
    logic          e_strobe, e_under;
    logic [15:0]   e_ucnt;

    initial begin
        m_req = 0; m_wait = 0; m_drop = 0;
        e_audio = '0; e_strobe = 0; e_under = 0; e_ucnt = '0;
    end

    task automatic m_reset();
        m_req = 0; m_wait = 0; m_drop = 0;
        m_fifo.delete();
        m_slices.delete();
        e_audio = '0; e_strobe = 0; e_under = 0; e_ucnt = '0;
    endtask

    task automatic m_step();
        int sz0 = m_fifo.size();
        logic [SW-1:0] s;
        e_strobe = 0;
        e_under  = 0;
        if (sample_tick) begin
            if (!flush && sz0 > 0) begin
                e_audio  = m_fifo.pop_front();
                e_strobe = 1;
            end else begin
                e_under = 1;
                if (e_ucnt != 16'hFFFF) e_ucnt = e_ucnt + 16'd1;
            end
        end
        if (m_req) begin
            m_req = 0;
            if (flush) m_drop = 1; else m_wait = 1;
        end else if (m_wait) begin
            if (flush) begin
                m_wait = 0;
                m_drop = !data_valid;
            end else if (data_valid) begin
                m_wait = 0;
                for (int i = 0; i < SPW; i++) begin
                    s = read_data[i*SW +: SW];
                    if (reverse) m_slices.push_front(s);
                    else         m_slices.push_back(s);
                end
            end
        end else if (m_drop) begin
            if (data_valid) m_drop = 0;
        end else if (m_slices.size() > 0) begin
            if (flush) m_slices.delete();
            else       m_fifo.push_back(m_slices.pop_front());
        end else if (enable && !flush && (DEPTH - sz0 >= SPW)) begin
            m_req = 1;
        end
        if (flush) m_fifo.delete();
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) m_reset();
        else       m_step();
    end

    always @(negedge clock) begin
        chk("word_request", word_request, m_req);
        chk("audio_out", audio_out, e_audio);
        chk("sample_strobe", sample_strobe, e_strobe);
        chk("underrun", underrun, e_under);
        chk("fill_level", fill_level, m_fifo.size());
        chk("underrun_count", underrun_count, e_ucnt);
    end

    // ---------------- stimulus ----------------
    logic [WW-1:0] words_q[$];
    int  resp_cnt  = 0;
    int  resp_lat  = 1;
    bit  auto_serve = 0;
    int  req_seen = 0, u_seen = 0, s_seen = 0;

    task automatic step();
        @(negedge clock);
        sample_tick = 0;
        flush       = 0;
        data_valid  = 0;
        if (word_request)  req_seen++;
        if (underrun)      u_seen++;
        if (sample_strobe) s_seen++;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                data_valid = 1;
                read_data  = (words_q.size() > 0) ? words_q.pop_front() : WW'($urandom);
            end
        end
        if (auto_serve && word_request) resp_cnt = resp_lat;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 40; i++) begin
            step();
            if (word_request) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_req: no word_request within 40 cycles at %0t", $time);
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, "_req"}, word_request, 0);
        chk({tag, "_audio"}, audio_out, 0);
        chk({tag, "_strobe"}, sample_strobe, 0);
        chk({tag, "_under"}, underrun, 0);
        chk({tag, "_fill"}, fill_level, 0);
        chk({tag, "_ucnt"}, underrun_count, 0);
    endtask

    task automatic do_reset();
        #2 reset = 1;
        #1 zero_chk("rst");
        resp_cnt = 0;
        words_q.delete();
        @(negedge clock);
        #2 reset = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1; enable = 0; flush = 0; reverse = 0; sample_tick = 0;
        read_data = '0; data_valid = 0;
        step(); step();
        #2 reset = 0;
        zero_chk("init");

        // underrun from reset with enable low
        u_seen = 0; req_seen = 0;
        repeat (3) begin sample_tick = 1; step(); end
        step();
        chk("ur_pulses", u_seen, 3);
        chk("ur_count", underrun_count, 3);
        chk("ur_audio", audio_out, 0);
        chk("ur_noreq", req_seen, 0);

        // forward order
        step(); do_reset();
        words_q.push_back(32'hBEEF_1234);
        auto_serve = 1; resp_lat = 1; reverse = 0; enable = 1;
        wait_req();
        enable = 0;
        repeat (6) step();
        chk("fwd_fill", fill_level, 2);
        s_seen = 0;
        sample_tick = 1; step();
        chk("fwd_s0", audio_out, 16'h1234);
        chk("fwd_strobe0", sample_strobe, 1);
        sample_tick = 1; step();
        chk("fwd_s1", audio_out, 16'hBEEF);
        step();
        chk("fwd_strobes", s_seen, 2);
        chk("fwd_empty", fill_level, 0);

        // reverse order, reverse toggled during unpack
        step(); do_reset();
        words_q.push_back(32'hBEEF_1234);
        reverse = 1; enable = 1;
        wait_req();
        enable = 0;
        step(); step();
        reverse = 0;
        repeat (5) step();
        sample_tick = 1; step();
        chk("rev_s0", audio_out, 16'hBEEF);
        sample_tick = 1; step();
        chk("rev_s1", audio_out, 16'h1234);

        // fill and backpressure
        step(); do_reset();
        resp_lat = 1; enable = 1; req_seen = 0;
        repeat (30) step();
        chk("bp_reqs", req_seen, 2);
        chk("bp_full", fill_level, 4);
        chk("bp_req_low", word_request, 0);
        sample_tick = 1; step();
        repeat (9) step();
        chk("bp_fill3", fill_level, 3);
        chk("bp_reqs_still", req_seen, 2);
        sample_tick = 1; step();
        chk("bp_fill2", fill_level, 2);
        repeat (10) step();
        chk("bp_rerequest", req_seen, 3);
        enable = 0;

        // flush while waiting
        step(); do_reset();
        words_q.push_back(32'hAAAA_5555);
        words_q.push_back(32'h0002_0001);
        resp_lat = 3; enable = 1;
        wait_req();
        step();
        flush = 1;
        step(); step(); step();
        chk("fl_fill0", fill_level, 0);
        wait_req();
        enable = 0;
        repeat (8) step();
        chk("fl_fill2", fill_level, 2);
        sample_tick = 1; step();
        chk("fl_s0", audio_out, 16'h0001);
        sample_tick = 1; step();
        chk("fl_s1", audio_out, 16'h0002);

        // reset in the middle of unpack, then a stale data_valid
        step(); do_reset();
        words_q.push_back(32'h1234_5678);
        resp_lat = 1; enable = 1;
        wait_req();
        enable = 0;
        step(); step(); step();
        chk("mid_fill1", fill_level, 1);
        #2 reset = 1;
        #1 zero_chk("mid");
        step();
        #2 reset = 0;
        words_q.push_back(32'hDEAD_BEEF);
        resp_cnt = 1;
        repeat (4) step();
        chk("stale_fill", fill_level, 0);
        chk("stale_audio", audio_out, 0);

        // randomized run
        step(); do_reset();
        auto_serve = 1;
        for (int blk = 0; blk < 15; blk++) begin
            int tick_mod = $urandom_range(1, 6);
            for (int i = 0; i < 200; i++) begin
                enable      = ($urandom_range(0, 9) != 0);
                reverse     = 1'($urandom_range(0, 1));
                sample_tick = ($urandom_range(0, tick_mod - 1) == 0);
                flush       = ($urandom_range(0, 59) == 0);
                resp_lat    = $urandom_range(1, 4);
                if (resp_cnt == 0 && $urandom_range(0, 49) == 0) resp_cnt = 1;
                step();
                if ($urandom_range(0, 799) == 0) do_reset();
            end
        end
        enable = 0;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
